culsans_err_slv: RTL and testbench
==================================

CULSANS_ERR_SLV -- requirements
Module: culsans_err_slv

Interface
REQ-001 Parameter RespCode, axi_pkg::resp_t, default axi_pkg::RESP_DECERR: resp code returned on every B and R beat.
REQ-002 Parameter ReadData, culsans_pkg::data_t, default 64'hDEAD_BEEF_DEAD_BEEF: data returned on every R beat.
REQ-003 Port clk_i  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst_ni  input  1: reset, asynchronous, active-low.
REQ-005 Port slv_req_i  input  culsans_pkg::req_slv_t: request from the crossbar master port (slave-side ID width IdWidthSlave).
REQ-006 Port slv_resp_o  output  culsans_pkg::resp_slv_t: response to the crossbar.

Function
REQ-007 Block SHALL terminate every transaction the crossbar routes to an unmapped address, with independent write and read paths that may be active in the same cycle.
REQ-008 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
REQ-009 W_IDLE: aw_ready=1, w_ready=0, b_valid=0; on aw_valid&aw_ready, capture aw.id and go to W_DATA.
REQ-010 W_DATA: aw_ready=0, w_ready=1; each w_valid beat is consumed and discarded; the beat with w.last=1 moves the FSM to W_RESP.
REQ-011 Beat count SHALL be governed only by w.last; aw.len is ignored on the write path.
REQ-012 W_RESP: b_valid=1, b.id=captured ID, b.resp=RespCode, b.user=0; hold all B fields stable until b_ready; on b_valid&b_ready return to W_IDLE.
REQ-013 W beats arriving before their AW SHALL be stalled (w_ready=0 in W_IDLE).
REQ-014 Read FSM SHALL have states R_IDLE, R_DATA.
REQ-015 R_IDLE: ar_ready=1, r_valid=0; on ar_valid&ar_ready, capture ar.id, load 8-bit beat counter with ar.len, go to R_DATA.
REQ-016 R_DATA: ar_ready=0, r_valid=1, r.id=captured ID, r.data=ReadData, r.resp={2'b00,RespCode} (PassDirty=0, IsShared=0), r.user=0, r.last=(counter==0).
REQ-017 Each r_valid&r_ready handshake with counter>0 SHALL decrement the counter by 1; the handshake with counter==0 returns to R_IDLE.
REQ-018 R fields SHALL stay stable while r_valid=1 and r_ready=0.
REQ-019 Latency: AR handshake in cycle N gives first r_valid in cycle N+1; AW handshake in N gives w_ready in N+1; last-W handshake in M gives b_valid in M+1.
REQ-020 One outstanding transaction per direction; one-cycle bubble minimum between back-to-back transactions on the same channel.
REQ-021 ar.len=255 SHALL yield exactly 256 R beats; counter SHALL not wrap.
REQ-022 ATOP, snoop, bar, domain and awunique fields SHALL be ignored; all AWs are treated as plain writes (atomics are filtered upstream).
REQ-023 No combinational path from any slv_req_i field to any ready/valid output except through FSM state.

Reset
REQ-024 While rst_ni=0: both FSMs in idle, counter=0, captured IDs=0, outputs aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, all data/id/resp fields 0.
REQ-025 Reset asserted mid-transaction SHALL abort it immediately; no residual B or R beat is issued after rst_ni rises.

Verification
REQ-026 AW id=6'h2A len=3, four W beats last on 4th -> exactly one B, id=6'h2A, resp=2'b11, b_valid in cycle after last W.
REQ-027 AR id=6'h15 len=0 -> single R beat cycle N+1, last=1, data=64'hDEAD_BEEF_DEAD_BEEF, resp=4'b0011.
REQ-028 AR len=255 with r_ready toggled randomly -> 256 beats, last only on 256th, fields stable during stalls.
REQ-029 AW and AR in same cycle, b_ready=0 for 10 cycles -> read burst completes independently; B held with stable id until b_ready.
REQ-030 W valid asserted before AW -> w_ready=0 until cycle after AW handshake; no beat lost.
REQ-031 rst_ni pulled low during R beat 2 of len=7 -> r_valid=0 asynchronously; after release, no further R beats; next AR served normally.

Source files
------------

// File: rtl/culsans_err_slv.sv
// culsans_err_slv: error slave terminating crossbar transactions to unmapped addresses.
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset
//   slv_req_i  - request channels from the crossbar master port
//   slv_resp_o - response channels to the crossbar (every B/R beat carries RespCode)

package axi_pkg;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
endpackage

package culsans_pkg;
    localparam int unsigned IdWidthSlave = 6;
    localparam int unsigned AddrWidth    = 64;
    localparam int unsigned DataWidth    = 64;
    localparam int unsigned UserWidth    = 1;
    typedef logic [IdWidthSlave-1:0]  id_slv_t;
    typedef logic [AddrWidth-1:0]     addr_t;
    typedef logic [DataWidth-1:0]     data_t;
    typedef logic [DataWidth/8-1:0]   strb_t;
    typedef logic [UserWidth-1:0]     user_t;
    typedef struct packed {
        id_slv_t     id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        user_t       user;
        logic [2:0]  snoop;
        logic [1:0]  bar;
        logic [1:0]  domain;
        logic        awunique;
    } aw_chan_t;
    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;
    typedef struct packed {
        id_slv_t     id;
        logic [1:0]  resp;
        user_t       user;
    } b_chan_t;
    typedef struct packed {
        id_slv_t     id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        user_t       user;
        logic [3:0]  snoop;
        logic [1:0]  bar;
        logic [1:0]  domain;
    } ar_chan_t;
    typedef struct packed {
        id_slv_t     id;
        data_t       data;
        logic [3:0]  resp;
        logic        last;
        user_t       user;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_slv_t;
    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_slv_t;
endpackage

module culsans_err_slv #(
    parameter axi_pkg::resp_t     RespCode = axi_pkg::RESP_DECERR,
    parameter culsans_pkg::data_t ReadData = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  culsans_pkg::req_slv_t  slv_req_i,
    output culsans_pkg::resp_slv_t slv_resp_o
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    culsans_pkg::id_slv_t b_id_q, b_id_d, r_id_q, r_id_d;
    logic [7:0]           cnt_q, cnt_d;
    // Address, data payload and ACE attributes are deliberately discarded.
    logic                 unused_req;
    assign unused_req = ^slv_req_i;
    // All ready/valid outputs derive from state only; request fields only steer next state.
    always_comb begin
        slv_resp_o = '0;
        w_state_d  = w_state_q;
        r_state_d  = r_state_q;
        b_id_d     = b_id_q;
        r_id_d     = r_id_q;
        cnt_d      = cnt_q;
        case (w_state_q)
            W_IDLE: begin
                slv_resp_o.aw_ready = 1'b1;
                if (slv_req_i.aw_valid) begin
                    b_id_d    = slv_req_i.aw.id;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                slv_resp_o.w_ready = 1'b1;
                if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_RESP;
            end
            W_RESP: begin
                slv_resp_o.b_valid = 1'b1;
                slv_resp_o.b.id    = b_id_q;
                slv_resp_o.b.resp  = RespCode;
                if (slv_req_i.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE: begin
                slv_resp_o.ar_ready = 1'b1;
                if (slv_req_i.ar_valid) begin
                    r_id_d    = slv_req_i.ar.id;
                    cnt_d     = slv_req_i.ar.len;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                slv_resp_o.r_valid = 1'b1;
                slv_resp_o.r.id    = r_id_q;
                slv_resp_o.r.data  = ReadData;
                slv_resp_o.r.resp  = {2'b00, RespCode};
                slv_resp_o.r.last  = (cnt_q == 8'd0);
                // Counter stops at zero: the final beat exits instead of wrapping.
                if (slv_req_i.r_ready) begin
                    if (cnt_q == 8'd0) r_state_d = R_IDLE;
                    else cnt_d = cnt_q - 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            b_id_q    <= '0;
            r_id_q    <= '0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            b_id_q    <= b_id_d;
            r_id_q    <= r_id_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_culsans_err_slv.sv
// tb_culsans_err_slv: scoreboard bench for the error slave.
module tb_culsans_err_slv;
    import culsans_pkg::*;
    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    req_slv_t  req;
    resp_slv_t resp;
    r_chan_t   exp_r[$];
    b_chan_t   exp_b[$];
    int        n_tests = 0;
    int        n_fail = 0;
    logic      r_stall = 1'b0;
    logic      b_stall = 1'b0;
    r_chan_t   r_hold;
    b_chan_t   b_hold;

    culsans_err_slv dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [5:0] id, input int n);
        for (int i = 0; i < n; i++)
            exp_r.push_back('{id: id, data: 64'hDEAD_BEEF_DEAD_BEEF, resp: 4'b0011, last: (i == n - 1), user: 1'b0});
    endtask

    task automatic push_b(input logic [5:0] id);
        exp_b.push_back('{id: id, resp: 2'b11, user: 1'b0});
    endtask

    task automatic send_aw(input logic [5:0] id, input logic [7:0] len);
        int t = 0;
        req.aw.id = id;
        req.aw.len = len;
        req.aw_valid = 1'b1;
        while (!resp.aw_ready && t < 100) begin tick(); t++; end
        check("aw_accept", resp.aw_ready, 1);
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic last);
        int t = 0;
        req.w.data = {$urandom, $urandom};
        req.w.last = last;
        req.w_valid = 1'b1;
        while (!resp.w_ready && t < 100) begin tick(); t++; end
        check("w_accept", resp.w_ready, 1);
        tick();
        req.w_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [7:0] len);
        int t = 0;
        req.ar.id = id;
        req.ar.len = len;
        req.ar_valid = 1'b1;
        while (!resp.ar_ready && t < 100) begin tick(); t++; end
        check("ar_accept", resp.ar_ready, 1);
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic drain_r(input int budget);
        int t = 0;
        while (exp_r.size() != 0 && t < budget) begin tick(); t++; end
        check("r_drain", exp_r.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) check("r_stable", {resp.r_valid, resp.r}, {1'b1, r_hold});
            if (b_stall) check("b_stable", {resp.b_valid, resp.b}, {1'b1, b_hold});
            if (resp.r_valid && req.r_ready) begin
                if (exp_r.size() == 0) check("r_unexpected", resp.r, 0);
                else check("r_beat", resp.r, exp_r.pop_front());
            end
            if (resp.b_valid && req.b_ready) begin
                if (exp_b.size() == 0) check("b_unexpected", resp.b, 0);
                else check("b_beat", resp.b, exp_b.pop_front());
            end
            r_stall = resp.r_valid && !req.r_ready;
            b_stall = resp.b_valid && !req.b_ready;
            r_hold = resp.r;
            b_hold = resp.b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_aw_ready", resp.aw_ready, 1);
        check("rst_ar_ready", resp.ar_ready, 1);
        check("rst_w_ready", resp.w_ready, 0);
        check("rst_b_valid", resp.b_valid, 0);
        check("rst_r_valid", resp.r_valid, 0);
        check("rst_b_fields", resp.b, 0);
        check("rst_r_fields", resp.r, 0);
        rst_n = 1'b1;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        tick();

        // Four-beat write burst, B in the cycle after the last W
        check("w_idle_stall", resp.w_ready, 0);
        push_b(6'h2A);
        send_aw(6'h2A, 8'd3);
        check("aw_to_w_lat", resp.w_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("b_not_early", resp.b_valid, 0);
            send_w(i == 3);
        end
        check("b_lat", resp.b_valid, 1);
        check("b_id", resp.b.id, 6'h2A);
        tick();
        check("b_single", resp.b_valid, 0);
        check("b_queue_empty", exp_b.size(), 0);

        // Single-beat read
        push_r(6'h15, 1);
        send_ar(6'h15, 8'd0);
        check("r_lat", resp.r_valid, 1);
        check("r_last_single", resp.r.last, 1);
        tick();
        check("r_single", resp.r_valid, 0);
        check("r_queue_empty", exp_r.size(), 0);

        // 256-beat read with random back-pressure
        push_r(6'h07, 256);
        send_ar(6'h07, 8'd255);
        begin
            int t = 0;
            while (exp_r.size() != 0 && t < 3000) begin
                req.r_ready = 1'($urandom_range(0, 1));
                tick();
                t++;
            end
        end
        req.r_ready = 1'b1;
        check("r256_drain", exp_r.size(), 0);
        check("r256_done", resp.r_valid, 0);
        tick();
        check("r256_no_extra", resp.r_valid, 0);

        // Simultaneous AW and AR with B held off
        req.b_ready = 1'b0;
        push_r(6'h22, 4);
        push_b(6'h11);
        req.aw.id = 6'h11;
        req.aw.len = 8'd0;
        req.ar.id = 6'h22;
        req.ar.len = 8'd3;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        check("dual_aw_ready", resp.aw_ready, 1);
        check("dual_ar_ready", resp.ar_ready, 1);
        tick();
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        check("dual_r_valid", resp.r_valid, 1);
        send_w(1'b1);
        repeat (10) tick();
        check("dual_r_done", exp_r.size(), 0);
        check("dual_b_held", resp.b_valid, 1);
        check("dual_b_id", resp.b.id, 6'h11);
        req.b_ready = 1'b1;
        tick();
        check("dual_b_done", resp.b_valid, 0);
        check("dual_b_queue", exp_b.size(), 0);

        // W presented before AW
        push_b(6'h3C);
        req.w.last = 1'b0;
        req.w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("w_early_stall", resp.w_ready, 0);
            tick();
        end
        req.aw.id = 6'h3C;
        req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        check("w_after_aw", resp.w_ready, 1);
        tick();
        check("w_first_beat_kept", resp.b_valid, 0);
        req.w.last = 1'b1;
        tick();
        req.w_valid = 1'b0;
        check("w_early_b", resp.b_valid, 1);
        tick();
        check("w_early_b_queue", exp_b.size(), 0);

        // Reset during beat 2 of an 8-beat read
        push_r(6'h33, 2);
        exp_r[1].last = 1'b0;
        send_ar(6'h33, 8'd7);
        tick();
        tick();
        check("pre_rst_r_valid", resp.r_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_r_valid", resp.r_valid, 0);
        check("rst_async_r_fields", resp.r, 0);
        check("rst_async_ar_ready", resp.ar_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        check("rst_no_residual", resp.r_valid, 0);
        check("rst_queue_empty", exp_r.size(), 0);
        push_r(6'h0C, 2);
        send_ar(6'h0C, 8'd1);
        check("post_rst_r_valid", resp.r_valid, 1);
        drain_r(20);
        tick();
        check("post_rst_idle", resp.r_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
